// File: rtl/baud_pkg.sv
// Shared state type, default widths and counter-width helper for the
// fractional baud generator.
package baud_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } baud_state_t;

    localparam int unsigned IBRD_W_DEF     = 16;
    localparam int unsigned FBRD_W_DEF     = 6;
    localparam int unsigned OVERSAMPLE_DEF = 16;

    function automatic int unsigned os_cnt_w(input int unsigned oversample);
        return (oversample > 1) ? $clog2(oversample) : 1;
    endfunction

endpackage

// File: rtl/baud_frac_gen_if.sv
// Divisor programming and tick outputs of the baud generator, as seen by the
// register file (master) and the generator itself (slave).
interface baud_frac_gen_if
    import baud_pkg::*;
#(
    parameter int unsigned IBRD_W = IBRD_W_DEF,
    parameter int unsigned FBRD_W = FBRD_W_DEF
) ();

    logic              enable;
    logic [IBRD_W-1:0] ibrd;
    logic [FBRD_W-1:0] fbrd;
    logic              load;
    logic              tick_os;
    logic              tick_bit;
    logic              tick_mid;
    logic              baud_level;
    logic              running;
    logic              div_err;

    modport master (
        output enable, ibrd, fbrd, load,
        input  tick_os, tick_bit, tick_mid, baud_level, running, div_err
    );

    modport slave (
        input  enable, ibrd, fbrd, load,
        output tick_os, tick_bit, tick_mid, baud_level, running, div_err
    );

endinterface

// File: rtl/baud_frac_core.sv
// Period counter plus phase accumulator: produces the registered oversample
// tick, with the fractional carry stretching the following period by a clock.
module baud_frac_core #(
    parameter int unsigned IBRD_W = 16,
    parameter int unsigned FBRD_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              run,
    input  logic [IBRD_W-1:0] ibrd_nx,
    input  logic [FBRD_W-1:0] fbrd,
    output logic              tick,
    output logic              tick_nx
);

    localparam logic [IBRD_W:0] ONE = (IBRD_W+1)'(1);

    logic [IBRD_W:0]   cnt, cnt_d;
    logic [IBRD_W:0]   len, len_d;
    logic [FBRD_W-1:0] acc, acc_d;
    logic              carry;

    // Neither start nor run means idle: everything, including the phase, clears.
    always_comb begin
        cnt_d   = '0;
        len_d   = '0;
        acc_d   = '0;
        carry   = 1'b0;
        tick_nx = 1'b0;
        if (start) begin
            cnt_d   = ONE;
            len_d   = {1'b0, ibrd_nx};
            tick_nx = (len_d == ONE);
        end else if (run) begin
            if (tick) begin
                {carry, acc_d} = {1'b0, acc} + {1'b0, fbrd};
                len_d   = {1'b0, ibrd_nx} + {{IBRD_W{1'b0}}, carry};
                cnt_d   = ONE;
                tick_nx = (len_d == ONE);
            end else begin
                acc_d   = acc;
                len_d   = len;
                cnt_d   = cnt + ONE;
                tick_nx = (cnt_d == len);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt  <= '0;
            len  <= '0;
            acc  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_d;
            len  <= len_d;
            acc  <= acc_d;
            tick <= tick_nx;
        end
    end

endmodule

// File: rtl/baud_frac_gen.sv
// Fractional baud generator: shadow/active divisor registers, run FSM and the
// oversample-to-bit tick derivation around baud_frac_core.
module baud_frac_gen
    import baud_pkg::*;
#(
    parameter int unsigned IBRD_W     = IBRD_W_DEF,
    parameter int unsigned FBRD_W     = FBRD_W_DEF,
    parameter int unsigned OVERSAMPLE = OVERSAMPLE_DEF
) (
    input logic            clock,
    input logic            reset,
    baud_frac_gen_if.slave bus
);

    localparam int unsigned     OS_W    = os_cnt_w(OVERSAMPLE);
    localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0] OS_ONE  = OS_W'(1);

    baud_state_t       state, state_d;
    logic [IBRD_W-1:0] sh_ibrd, act_ibrd, act_ibrd_d;
    logic [FBRD_W-1:0] sh_fbrd, act_fbrd, act_fbrd_d;
    logic [OS_W-1:0]   os_cnt, os_d;
    logic              start, stay;
    logic              tick_os, tick_nx;
    logic              tick_bit_q, tick_mid_q, baud_q, div_err_q;

    // A load on the tick cycle bypasses the shadow so it governs the very next period.
    always_comb begin
        state_d    = state;
        start      = 1'b0;
        stay       = 1'b0;
        act_ibrd_d = act_ibrd;
        act_fbrd_d = act_fbrd;
        if (state == IDLE) begin
            act_ibrd_d = sh_ibrd;
            act_fbrd_d = sh_fbrd;
        end else if (tick_os) begin
            act_ibrd_d = bus.load ? bus.ibrd : sh_ibrd;
            act_fbrd_d = bus.load ? bus.fbrd : sh_fbrd;
        end
        case (state)
            IDLE: begin
                if (bus.enable && act_ibrd != '0) begin
                    state_d = RUN;
                    start   = 1'b1;
                end
            end
            RUN: begin
                if (bus.enable && act_ibrd_d != '0) stay = 1'b1;
                else                                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        os_d = '0;
        if (stay) os_d = tick_os ? os_cnt + OS_ONE : os_cnt;
    end

    baud_frac_core #(
        .IBRD_W (IBRD_W),
        .FBRD_W (FBRD_W)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .run     (stay),
        .ibrd_nx (act_ibrd_d),
        .fbrd    (act_fbrd),
        .tick    (tick_os),
        .tick_nx (tick_nx)
    );

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= IDLE;
            sh_ibrd    <= '0;
            sh_fbrd    <= '0;
            act_ibrd   <= '0;
            act_fbrd   <= '0;
            os_cnt     <= '0;
            tick_bit_q <= 1'b0;
            tick_mid_q <= 1'b0;
            baud_q     <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            state <= state_d;
            if (bus.load) begin
                sh_ibrd <= bus.ibrd;
                sh_fbrd <= bus.fbrd;
            end
            act_ibrd   <= act_ibrd_d;
            act_fbrd   <= act_fbrd_d;
            os_cnt     <= os_d;
            tick_bit_q <= tick_nx && (os_d == OS_LAST);
            tick_mid_q <= tick_nx && (os_d == OS_MID);
            baud_q     <= stay && (baud_q ^ tick_bit_q);
            div_err_q  <= bus.enable && (act_ibrd_d == '0);
        end
    end

    assign bus.tick_os    = tick_os;
    assign bus.tick_bit   = tick_bit_q;
    assign bus.tick_mid   = tick_mid_q;
    assign bus.baud_level = baud_q;
    assign bus.running    = (state == RUN);
    assign bus.div_err    = div_err_q;

endmodule

// File: tb/tb_baud_frac_gen.sv
// Scoreboard bench for baud_frac_gen: expected tick cycles are queued as the
// divisor/enable stimulus is applied and popped as the DUT raises each tick.
module tb_baud_frac_gen;
    import baud_pkg::*;

    localparam int unsigned IBRD_W     = IBRD_W_DEF;
    localparam int unsigned FBRD_W     = FBRD_W_DEF;
    localparam int unsigned OVERSAMPLE = OVERSAMPLE_DEF;
    localparam int          OS         = int'(OVERSAMPLE);
    localparam int          FSCALE     = 1 << FBRD_W;

    logic clock = 1'b0;
    logic reset;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   n_exp = 0;
    int   q_os[$];
    int   q_bit[$];
    int   q_mid[$];
    int   seen_at[$];

    baud_frac_gen_if #(.IBRD_W(IBRD_W), .FBRD_W(FBRD_W)) bus ();

    baud_frac_gen #(
        .IBRD_W     (IBRD_W),
        .FBRD_W     (FBRD_W),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    task automatic run_to(input int c);
        while (cyc < c) step();
    endtask

    task automatic load_div(input int i, input int f);
        bus.load = 1'b1;
        bus.ibrd = IBRD_W'(i);
        bus.fbrd = FBRD_W'(f);
        step();
        bus.load = 1'b0;
    endtask

    task automatic push_tick(input int c);
        q_os.push_back(c);
        n_exp++;
        if (n_exp % OS == OS / 2) q_mid.push_back(c);
        if (n_exp % OS == 0)      q_bit.push_back(c);
    endtask

    // Expected tick cycles for a run whose first period begins the cycle after base.
    task automatic exp_run(input int base, input int ib, input int fb, input int n, output int last);
        int c     = base;
        int acc   = 0;
        int extra = 0;
        for (int k = 0; k < n; k++) begin
            c = c + ib + extra;
            push_tick(c);
            acc   = acc + fb;
            extra = (acc >= FSCALE) ? 1 : 0;
            acc   = acc % FSCALE;
        end
        last = c;
    endtask

    task automatic sb_start();
        q_os.delete();
        q_bit.delete();
        q_mid.delete();
        seen_at.delete();
        n_exp = 0;
    endtask

    task automatic sb_end(input string tag);
        chk({tag, "_os_left"},  q_os.size(),  0);
        chk({tag, "_bit_left"}, q_bit.size(), 0);
        chk({tag, "_mid_left"}, q_mid.size(), 0);
    endtask

    task automatic check_idle(input string tag);
        sample();
        chk({tag, "_tick_os"},  bus.tick_os,    1'b0);
        chk({tag, "_tick_bit"}, bus.tick_bit,   1'b0);
        chk({tag, "_tick_mid"}, bus.tick_mid,   1'b0);
        chk({tag, "_baud"},     bus.baud_level, 1'b0);
        chk({tag, "_running"},  bus.running,    1'b0);
        chk({tag, "_div_err"},  bus.div_err,    1'b0);
    endtask

    always @(negedge clock) begin
        if (bus.tick_os === 1'b1) begin
            seen_at.push_back(cyc);
            if (q_os.size() != 0) chk("tick_os_at", cyc, q_os.pop_front());
            else                  chk("tick_os_extra", cyc, 0);
        end
        if (bus.tick_bit === 1'b1) begin
            if (q_bit.size() != 0) chk("tick_bit_at", cyc, q_bit.pop_front());
            else                   chk("tick_bit_extra", cyc, 0);
        end
        if (bus.tick_mid === 1'b1) begin
            if (q_mid.size() != 0) chk("tick_mid_at", cyc, q_mid.pop_front());
            else                   chk("tick_mid_extra", cyc, 0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n0, m, l, last;

        reset      = 1'b0;
        bus.enable = 1'b0;
        bus.load   = 1'b0;
        bus.ibrd   = '0;
        bus.fbrd   = '0;
        sb_start();
        step();
        step();
        check_idle("rst");
        reset = 1'b1;
        step();

        // Integer divisor 4: oversample every 4, mid at 32, bit at 64.
        load_div(4, 0);
        step();
        n0 = cyc;
        bus.enable = 1'b1;
        exp_run(n0, 4, 0, 48, last);
        sample();
        chk("t1_run_pre", bus.running, 1'b0);
        step();
        sample();
        chk("t1_run_rise", bus.running, 1'b1);
        chk("t1_div_err", bus.div_err, 1'b0);
        run_to(n0 + 64);
        sample();
        chk("t1_baud_pre", bus.baud_level, 1'b0);
        step();
        sample();
        chk("t1_baud_rise", bus.baud_level, 1'b1);
        run_to(last + 1);
        sample();
        chk("t1_baud_hold", bus.baud_level, 1'b1);
        bus.enable = 1'b0;
        step();
        check_idle("t1_off");
        sb_end("t1");

        // Divisor 4.5: alternating 4/5 periods after the first two.
        sb_start();
        load_div(4, 32);
        step();
        n0 = cyc;
        bus.enable = 1'b1;
        exp_run(n0, 4, 32, 66, last);
        run_to(last);
        sample();
        bus.enable = 1'b0;
        step();
        check_idle("t2_off");
        if (seen_at.size() >= 65) chk("t2_span64", seen_at[64] - seen_at[0], 288);
        else                      chk("t2_tick_count", seen_at.size(), 65);
        sb_end("t2");

        // Zero divisor holds in IDLE with div_err; loading 3 starts the generator.
        sb_start();
        load_div(0, 0);
        step();
        bus.enable = 1'b1;
        step();
        step();
        sample();
        chk("t3_div_err", bus.div_err, 1'b1);
        chk("t3_running", bus.running, 1'b0);
        run_to(cyc + 10);
        l = cyc;
        load_div(3, 0);
        sample();
        chk("t3_err_hold", bus.div_err, 1'b1);
        step();
        sample();
        chk("t3_err_clr", bus.div_err, 1'b0);
        chk("t3_run_pre", bus.running, 1'b0);
        step();
        sample();
        chk("t3_run_rise", bus.running, 1'b1);
        exp_run(l + 2, 3, 0, 10, last);
        run_to(last);
        sample();
        bus.enable = 1'b0;
        step();
        check_idle("t3_off");
        sb_end("t3");

        // Mid-period load waits for the tick; load on the tick applies immediately after.
        sb_start();
        load_div(10, 0);
        step();
        n0 = cyc;
        bus.enable = 1'b1;
        push_tick(n0 + 10);
        push_tick(n0 + 20);
        push_tick(n0 + 30);
        push_tick(n0 + 35);
        push_tick(n0 + 40);
        push_tick(n0 + 47);
        push_tick(n0 + 54);
        run_to(n0 + 23);
        load_div(5, 0);
        run_to(n0 + 40);
        load_div(7, 0);
        run_to(n0 + 54);
        sample();
        bus.enable = 1'b0;
        step();
        check_idle("t4_off");
        sb_end("t4");

        // Disable three clocks into a period, then restart with a full period.
        sb_start();
        load_div(6, 0);
        step();
        n0 = cyc;
        bus.enable = 1'b1;
        push_tick(n0 + 6);
        push_tick(n0 + 12);
        run_to(n0 + 15);
        sample();
        chk("t5_run_mid", bus.running, 1'b1);
        bus.enable = 1'b0;
        step();
        check_idle("t5_off");
        run_to(n0 + 18);
        m = cyc;
        n_exp = 0;
        bus.enable = 1'b1;
        exp_run(m, 6, 0, 2, last);
        run_to(last);
        sample();
        bus.enable = 1'b0;
        step();
        check_idle("t5_off2");
        sb_end("t5");

        // Reset pulse mid-run clears everything including the shadow divisor.
        sb_start();
        load_div(5, 0);
        step();
        n0 = cyc;
        bus.enable = 1'b1;
        push_tick(n0 + 5);
        push_tick(n0 + 10);
        run_to(n0 + 12);
        reset = 1'b0;
        step();
        check_idle("t6_rst");
        reset = 1'b1;
        step();
        sample();
        chk("t6_div_err", bus.div_err, 1'b1);
        step();
        step();
        sample();
        chk("t6_err_hold", bus.div_err, 1'b1);
        chk("t6_running", bus.running, 1'b0);
        step();
        l = cyc;
        n_exp = 0;
        load_div(5, 0);
        exp_run(l + 2, 5, 0, 3, last);
        step();
        sample();
        chk("t6_err_clr", bus.div_err, 1'b0);
        run_to(last);
        sample();
        bus.enable = 1'b0;
        step();
        check_idle("t6_off");
        sb_end("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
